// File: rtl/mat_stream.sv
// rtl/mat_stream.sv - M x M operand streamer feeding the systolic skew stage.
// Optional macro MAT_STREAM_TRANSPOSE_EN: emit stored rows whole (B-operand orientation).
module mat_stream #(
   parameter int M = 3
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 wr_en,
   input  logic [$clog2(M)-1:0] wr_row,
   input  logic [8*M-1:0]       wr_data,
   input  logic                 start,
   output logic                 busy,
   output logic [8*M-1:0]       vec_out,
   output logic                 vec_valid,
   output logic                 done
);

   localparam int RW = $clog2(M);
   localparam int CW = $clog2(2*M);

   typedef enum logic [1:0] {IDLE, STREAM, FLUSH, DONE} state_t;

   state_t          state;
   logic [CW-1:0]   cnt;
   logic [8*M-1:0]  mem [M];
   logic [8*M-1:0]  stream_vec;
   logic [RW-1:0]   cnt_row;

   // Element k sits in the MSB-first byte order, so shift it to the top byte.
   function automatic logic [7:0] elem(input logic [8*M-1:0] row, input logic [CW-1:0] k);
      logic [8*M-1:0] sh;
      sh = row << (8 * k);
      return sh[8*M-1 -: 8];
   endfunction

   assign cnt_row = cnt[RW-1:0];

   always_comb begin
      stream_vec = '0;
      for (int i = 0; i < M; i++) begin
`ifdef MAT_STREAM_TRANSPOSE_EN
         stream_vec[8*(M-i)-1 -: 8] = elem(mem[cnt_row], CW'(i));
`else
         stream_vec[8*(M-i)-1 -: 8] = elem(mem[i], cnt);
`endif
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state     <= IDLE;
         cnt       <= '0;
         busy      <= 1'b0;
         vec_out   <= '0;
         vec_valid <= 1'b0;
         done      <= 1'b0;
         for (int r = 0; r < M; r++) mem[r] <= '0;
      end else begin
         case (state)
            IDLE: begin
               busy      <= 1'b0;
               done      <= 1'b0;
               vec_valid <= 1'b0;
               vec_out   <= '0;
               if (wr_en && int'(wr_row) < M) mem[wr_row] <= wr_data;
               if (start) begin
                  cnt   <= '0;
                  state <= STREAM;
               end
            end
            STREAM: begin
               busy      <= 1'b1;
               vec_out   <= stream_vec;
               vec_valid <= 1'b1;
               if (cnt == CW'(M-1)) begin
                  cnt   <= '0;
                  state <= FLUSH;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            FLUSH: begin
               // Zeros let the skewed lanes drain through feed and the array.
               vec_out   <= '0;
               vec_valid <= 1'b0;
               if (cnt == CW'(2*M-3)) begin
                  cnt   <= '0;
                  state <= DONE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            DONE: begin
               done    <= 1'b1;
               busy    <= 1'b1;
               vec_out <= '0;
               state   <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mat_stream.sv
// tb/tb_mat_stream.sv - directed bench for mat_stream with a phase-based reference model.
module tb_mat_stream;

   localparam int M   = 3;
   localparam int OCC = 3*M - 1;

   logic        CLK = 1'b0;
   logic        RST, wr_en, start;
   logic [1:0]  wr_row;
   logic [23:0] wr_data;
   logic        busy, vec_valid, done;
   logic [23:0] vec_out;

   int total = 0;
   int bad   = 0;
   bit chk_en = 0;

   int mat [M][M];
   int s = -1;

   mat_stream #(.M(M)) dut (
      .CLK(CLK), .RST(RST), .wr_en(wr_en), .wr_row(wr_row), .wr_data(wr_data),
      .start(start), .busy(busy), .vec_out(vec_out), .vec_valid(vec_valid), .done(done)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [23:0] exp_vec(input int k);
      logic [23:0] v;
      v = '0;
      for (int i = 0; i < M; i++) begin
`ifdef MAT_STREAM_TRANSPOSE_EN
         v = (v << 8) | 24'(mat[k][i]);
`else
         v = (v << 8) | 24'(mat[i][k]);
`endif
      end
      return v;
   endfunction

   // s counts edges since the start was accepted; -1 means no stream in flight.
   always @(posedge CLK) begin
      if (RST) begin
         s = -1;
         for (int r = 0; r < M; r++)
            for (int k = 0; k < M; k++) mat[r][k] = 0;
      end else if (s < 0 || s == OCC) begin
         if (wr_en && wr_row < M)
            for (int k = 0; k < M; k++) mat[wr_row][k] = int'((wr_data >> (8*(M-1-k))) & 24'hFF);
         s = start ? 0 : -1;
      end else begin
         s = s + 1;
      end
   end

   always @(posedge CLK) begin
      #1;
      if (chk_en) begin
         logic eb, ev, ed;
         logic [23:0] evec;
         eb   = (s >= 1 && s <= OCC);
         ev   = (s >= 1 && s <= M);
         ed   = (s == OCC);
         evec = ev ? exp_vec(s - 1) : 24'h0;
         check("model_busy", 32'(busy), 32'(eb));
         check("model_valid", 32'(vec_valid), 32'(ev));
         check("model_done", 32'(done), 32'(ed));
         check("model_vec", 32'(vec_out), 32'(evec));
      end
   end

   task automatic cyc();
      @(posedge CLK);
      #1;
   endtask

   task automatic wr(input logic [1:0] row, input logic [23:0] data);
      wr_en = 1'b1; wr_row = row; wr_data = data;
      cyc();
      wr_en = 1'b0;
   endtask

   task automatic load();
      wr(2'd0, 24'h010203);
      wr(2'd1, 24'h040506);
      wr(2'd2, 24'h070809);
   endtask

`ifdef MAT_STREAM_TRANSPOSE_EN
   localparam logic [23:0] V0 = 24'h010203, V1 = 24'h040506, V2 = 24'h070809, V0B = 24'h010203;
`else
   localparam logic [23:0] V0 = 24'h010407, V1 = 24'h020508, V2 = 24'h030609, V0B = 24'h01AA07;
`endif

   initial begin
      RST = 1'b1; wr_en = 1'b0; start = 1'b0; wr_row = '0; wr_data = '0;
      cyc(); cyc();
      RST = 1'b0;
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_vec", 32'(vec_out), 32'd0);
      check("reset_valid", 32'(vec_valid), 32'd0);
      check("reset_done", 32'(done), 32'd0);
      chk_en = 1;

      load();
      wr(2'd3, 24'hDEADBE);

      // basic stream
      start = 1'b1; cyc(); start = 1'b0;
      cyc(); check("t1_vec_e1", 32'(vec_out), 32'(V0));
      cyc(); check("t1_vec_e2", 32'(vec_out), 32'(V1));
      cyc(); check("t1_vec_e3", 32'(vec_out), 32'(V2));
      repeat (4) cyc();
      check("t1_flush_e7", 32'(vec_out), 32'd0);
      cyc(); check("t1_done_e8", 32'(done), 32'd1);
      cyc(); check("t1_idle_e9", 32'(busy), 32'd0);

      // write together with start
      wr_en = 1'b1; wr_row = 2'd1; wr_data = 24'hAABBCC; start = 1'b1;
      cyc(); wr_en = 1'b0; start = 1'b0;
      cyc(); check("t2_vec_e1", 32'(vec_out), 32'(V0B));
      repeat (8) cyc();
      wr(2'd1, 24'h040506);

      // write and start ignored while streaming
      start = 1'b1; cyc(); start = 1'b0;
      cyc();
      wr_en = 1'b1; wr_row = 2'd0; wr_data = 24'hFFFFFF; start = 1'b1;
      cyc(); wr_en = 1'b0; start = 1'b0;
      check("t3_vec_e2", 32'(vec_out), 32'(V1));
      repeat (7) cyc();
      start = 1'b1; cyc(); start = 1'b0;
      cyc(); check("t3_row0_kept", 32'(vec_out), 32'(V0));
      repeat (8) cyc();

      // reset mid-stream
      start = 1'b1; cyc(); start = 1'b0;
      cyc();
      RST = 1'b1; cyc(); RST = 1'b0;
      check("t4_rst_vec", 32'(vec_out), 32'd0);
      check("t4_rst_valid", 32'(vec_valid), 32'd0);
      check("t4_rst_busy", 32'(busy), 32'd0);
      repeat (10) cyc();
      start = 1'b1; cyc(); start = 1'b0;
      cyc();
      check("t4_zero_vec", 32'(vec_out), 32'd0);
      check("t4_zero_valid", 32'(vec_valid), 32'd1);
      repeat (8) cyc();

      // start held high: back-to-back streams
      load();
      start = 1'b1; cyc();
      repeat (8) cyc(); check("t5_done_e8", 32'(done), 32'd1);
      cyc(); check("t5_e9_busy", 32'(busy), 32'd0);
      repeat (8) cyc(); check("t5_done_e17", 32'(done), 32'd1);
      start = 1'b0;
      repeat (4) cyc();

      chk_en = 0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
